mux_scan_sequencer: RTL and testbench

Controller that sequences the 8:1 latched-select multiplexer with registered, tri-stated complementary outputs. On each `start` it walks the enabled channels in ascending order. For each channel it drives the select lines, pulses the select-latch enable, lets the mux output register load, and samples `Y` into an 8-bit result. The mux outputs are enabled only while a scan is in progress. It sits between the host/control logic and the mux, and is the only driver of the mux's `S`, `LE` and `OE1`–`OE3` pins.

---
 rtl/mux_scan_sequencer.sv | 157 +++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Scan controller for an 8:1 latched-select mux: walks the enabled channels in
// ascending order, pulses the select latch per channel and collects Y into result.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 0
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] mask,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [2:0] S,
  output logic       LE,
  output logic       OE1,
  output logic       OE2,
  output logic       OE3,
  input  logic       Y
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LATCH,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] wait_q, wait_d;
  logic [2:0] s_q, s_d;
  logic       le_q, le_d;
  logic       oe1_q, oe2_q, oe3_q;
  logic       oe_act_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;

  logic [7:0] above_mask;
  logic [3:0] first_hit;
  logic [3:0] next_hit;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] lowest_set(input logic [7:0] m);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    above_mask = mask_q & ~((8'd2 << ch_q) - 8'd1);
    first_hit  = lowest_set(mask);
    next_hit   = lowest_set(above_mask);
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    wait_d   = wait_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d   = mask;
          result_d = 8'h00;
          if (first_hit[3]) begin
            ch_d    = first_hit[2:0];
            state_d = ST_SETUP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SETUP: state_d = ST_LATCH;
      ST_LATCH: begin
        if (SETTLE == 0) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) state_d = ST_SAMPLE;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_SAMPLE: begin
        result_d[ch_q] = Y;
        if (next_hit[3]) begin
          ch_d    = next_hit[2:0];
          state_d = ST_SETUP;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d   = state_d inside {ST_SETUP, ST_LATCH, ST_WAIT, ST_SAMPLE};
    oe_act_d = busy_d;
    le_d     = (state_d != ST_LATCH);
    done_d   = (state_d == ST_DONE);
    s_d      = busy_d ? ch_d : s_q;
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ch_q     <= 3'd0;
      mask_q   <= 8'h00;
      wait_q   <= 4'd0;
      s_q      <= 3'd0;
      le_q     <= 1'b1;
      oe1_q    <= 1'b1;
      oe2_q    <= 1'b1;
      oe3_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      wait_q   <= wait_d;
      s_q      <= s_d;
      le_q     <= le_d;
      oe1_q    <= ~oe_act_d;
      oe2_q    <= ~oe_act_d;
      oe3_q    <= oe_act_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign S      = s_q;
  assign LE     = le_q;
  assign OE1    = oe1_q;
  assign OE2    = oe2_q;
  assign OE3    = oe3_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=0 and SETTLE=2), each
// driving its own behavioural latched-select mux, checked against scan rules.
module tb_mux_scan_sequencer;

  logic       CP = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] mask_in;
  logic [7:0] d_in;

  logic [1:0] busy_o, done_o, le_o, oe1_o, oe2_o, oe3_o, y_o;
  logic [7:0] result_o [2];
  logic [2:0] s_o [2];

  int checks = 0;
  int errors = 0;

  always #5 CP = ~CP;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [2:0] sel_hold = 3'd0;
    logic       y_reg = 1'b0;

    mux_scan_sequencer #(.SETTLE(gi * 2)) u_dut (
      .CP    (CP),
      .RST   (RST),
      .start (start),
      .mask  (mask_in),
      .busy  (busy_o[gi]),
      .done  (done_o[gi]),
      .result(result_o[gi]),
      .S     (s_o[gi]),
      .LE    (le_o[gi]),
      .OE1   (oe1_o[gi]),
      .OE2   (oe2_o[gi]),
      .OE3   (oe3_o[gi]),
      .Y     (y_o[gi])
    );

    // Mux model: select latch transparent while LE is high, output register on CP.
    always @(posedge CP) begin
      if (le_o[gi]) sel_hold <= s_o[gi];
      y_reg <= d_in[le_o[gi] ? s_o[gi] : sel_hold];
    end

    assign y_o[gi] = (!oe1_o[gi] && !oe2_o[gi] && oe3_o[gi]) ? y_reg : 1'bz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s/dut%0d S", tag, i), 32'(s_o[i]), 32'd0);
      chk($sformatf("%s/dut%0d LE", tag, i), 32'(le_o[i]), 32'd1);
      chk($sformatf("%s/dut%0d OE", tag, i), 32'({oe1_o[i], oe2_o[i], oe3_o[i]}), 32'b110);
      chk($sformatf("%s/dut%0d busy", tag, i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("%s/dut%0d done", tag, i), 32'(done_o[i]), 32'd0);
      chk($sformatf("%s/dut%0d result", tag, i), 32'(result_o[i]), 32'd0);
    end
  endtask

  // One scan from IDLE. Entered and left on a falling edge. The model: channels are
  // the set mask bits in ascending order, each costing 3+SETTLE cycles, and the final
  // result is the mux data ANDed with the mask. toggle_c flips D[6] in that cycle,
  // restart_c pulses start for one cycle.
  task automatic do_scan(input string tag, input logic [7:0] m, input logic [7:0] d,
                         input int toggle_c, input int restart_c);
    int chans[$];
    int k;
    int per;
    int lat[2], busy_n[2], le_n[2], s_err[2], oe_err[2], done_n[2];
    k = 0;
    for (int n = 0; n < 8; n++) begin
      if (m[n]) begin
        chans.push_back(n);
        k++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      lat[i] = -1; busy_n[i] = 0; le_n[i] = 0; s_err[i] = 0; oe_err[i] = 0; done_n[i] = 0;
    end
    d_in    = d;
    mask_in = m;
    start   = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge CP);
      for (int i = 0; i < 2; i++) begin
        if (busy_o[i] === 1'b1) busy_n[i]++;
        if ({oe1_o[i], oe2_o[i], oe3_o[i]} !== ((busy_o[i] === 1'b1) ? 3'b001 : 3'b110))
          oe_err[i]++;
        if (le_o[i] === 1'b0) begin
          if (le_n[i] >= k || s_o[i] !== 3'(chans[le_n[i]])) s_err[i]++;
          le_n[i]++;
        end
        if (done_o[i] === 1'b1) begin
          done_n[i]++;
          if (lat[i] < 0) lat[i] = c;
        end
      end
      if (c == 1) begin
        start   = 1'b0;
        mask_in = 8'($urandom);
      end
      if (c == restart_c) start = 1'b1;
      if (c == restart_c + 1) start = 1'b0;
      if (c == toggle_c) d_in[6] = ~d_in[6];
    end
    for (int i = 0; i < 2; i++) begin
      per = 3 + 2 * i;
      chk($sformatf("%s/dut%0d done_latency", tag, i), 32'(lat[i]), 32'(1 + k * per));
      chk($sformatf("%s/dut%0d done_count", tag, i), 32'(done_n[i]), 32'd1);
      chk($sformatf("%s/dut%0d busy_cycles", tag, i), 32'(busy_n[i]), 32'(k * per));
      chk($sformatf("%s/dut%0d le_pulses", tag, i), 32'(le_n[i]), 32'(k));
      chk($sformatf("%s/dut%0d s_order_err", tag, i), 32'(s_err[i]), 32'd0);
      chk($sformatf("%s/dut%0d oe_err", tag, i), 32'(oe_err[i]), 32'd0);
      chk($sformatf("%s/dut%0d result", tag, i), 32'(result_o[i]), 32'(d_in & m));
      $display("scan %s dut%0d mask=%02h d=%02h result=%02h done_at=%0d", tag, i, m, d_in,
               result_o[i], lat[i]);
    end
  endtask

  initial begin
    int done_seen;
    RST     = 1'b1;
    start   = 1'b0;
    mask_in = 8'h00;
    d_in    = 8'h00;
    repeat (2) @(negedge CP);
    chk_reset("reset");
    RST = 1'b0;
    @(negedge CP);

    do_scan("full", 8'hFF, 8'hA5, -1, -1);
    do_scan("sparse", 8'h81, 8'hFF, -1, -1);

    // Empty mask, then start held high re-triggers a one-channel scan.
    d_in    = 8'h01;
    mask_in = 8'h00;
    start   = 1'b1;
    @(negedge CP);
    chk("empty/dut0 done", 32'(done_o[0]), 32'd1);
    chk("empty/dut1 done", 32'(done_o[1]), 32'd1);
    chk("empty/le", 32'(le_o), 32'b11);
    chk("empty/oe3", 32'(oe3_o), 32'b00);
    chk("empty/dut0 result", 32'(result_o[0]), 32'd0);
    mask_in = 8'h01;
    @(negedge CP);
    chk("retrig/idle busy", 32'(busy_o), 32'b00);
    chk("retrig/idle done", 32'(done_o), 32'b00);
    @(negedge CP);
    chk("retrig/busy", 32'(busy_o), 32'b11);
    start = 1'b0;
    repeat (15) @(negedge CP);
    chk("retrig/dut0 result", 32'(result_o[0]), 32'h01);
    chk("retrig/dut1 result", 32'(result_o[1]), 32'h01);
    $display("retrigger scan result0=%02h result1=%02h", result_o[0], result_o[1]);

    // Restart and mask change are ignored; D[6] flips during channel 6 SETUP of dut0.
    do_scan("disturb", 8'hFF, 8'($urandom), 19, 5);

    // Reset during channel 3 SAMPLE of dut0.
    mask_in = 8'hFF;
    d_in    = 8'($urandom);
    start   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CP);
      if (c == 1) start = 1'b0;
    end
    chk("rstmid/pre busy", 32'(busy_o[0]), 32'd1);
    chk("rstmid/pre S", 32'(s_o[0]), 32'd3);
    RST = 1'b1;
    @(negedge CP);
    chk_reset("rstmid");
    RST = 1'b0;
    done_seen = 0;
    repeat (50) begin
      @(negedge CP);
      if (done_o !== 2'b00) done_seen++;
    end
    chk("rstmid/no_done", 32'(done_seen), 32'd0);
    $display("reset mid-scan done_pulses=%0d", done_seen);
    do_scan("post_rst", 8'h5A, 8'($urandom), -1, -1);

    for (int r = 0; r < 6; r++) begin
      do_scan($sformatf("rand%0d", r), 8'($urandom), 8'($urandom), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
